mesm6_alu_iter: RTL

- Parametrised, multicycle successor of the BESM-6 integer/logical ALU. Operand width is configurable.
- Operations run over several cycles: shifts, pack/unpack and the optional multiply are iterative rather than single-cycle combinational.
- Uses an explicit start/busy/done handshake and holds the Y (low-mantissa) register.
- Sits between the accumulator/operand datapath and the control unit of the mesm6 core.

---
 rtl/mesm6_alu_iter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mesm6_alu_iter.sv
// mesm6_alu_iter: multicycle BESM-6 style integer/logical ALU holding the Y register.
// Single-cycle ops finish at the start edge; ADDC/COUNT/CLZ, SHIFT, PACK/UNPACK (and MUL)
// iterate in RUN. Define MESM6_ALU_MUL_EN to build the shift-add multiplier for op 11.
module mesm6_alu_iter #(
   parameter int unsigned WIDTH      = 48,
   parameter int unsigned SHIFT_STEP = 8,
   parameter int unsigned LANES      = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             wy,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW     = 7;               // counts up to 127 (shift amount, WIDTH<=64)
   localparam int unsigned NCHUNK = WIDTH / LANES;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_AND    = 4'd1;
   localparam logic [3:0] OP_OR     = 4'd2;
   localparam logic [3:0] OP_XOR    = 4'd3;
   localparam logic [3:0] OP_ADDC   = 4'd4;
   localparam logic [3:0] OP_COUNT  = 4'd5;
   localparam logic [3:0] OP_CLZ    = 4'd6;
   localparam logic [3:0] OP_SHIFT  = 4'd7;
   localparam logic [3:0] OP_PACK   = 4'd8;
   localparam logic [3:0] OP_UNPACK = 4'd9;
   localparam logic [3:0] OP_YTA    = 4'd10;
`ifdef MESM6_ALU_MUL_EN
   localparam logic [3:0] OP_MUL    = 4'd11;
`endif

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, result_q, y_q;
   logic [2*WIDTH-1:0] sh_q;      // shift pair, pack accumulator (low half), product pair
   logic [CW-1:0]      cnt_q;     // remaining shift distance or iteration index
   logic               busy_q, done_q;

   assign result = result_q;
   assign y      = y_q;
   assign busy   = busy_q;
   assign done   = done_q;

   logic [CW-1:0]      pop_c, clz_c, step_c;
   logic [WIDTH-1:0]   eac_x_c, eac_c, pk_acc_c, pk_a_c, pk_b_c;
   logic [WIDTH:0]     eac_s_c;
   logic [2*WIDTH-1:0] shf_c;

   // Per-cycle datapath: end-around adder, shifter step and one pack/unpack chunk.
   always_comb begin
      pop_c = '0;
      clz_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop_c = pop_c + CW'(a_q[i]);
         if (a_q[i]) clz_c = CW'(WIDTH - i);
      end
      case (op_q)
         OP_COUNT: eac_x_c = WIDTH'(pop_c);
         OP_CLZ:   eac_x_c = WIDTH'(clz_c);
         default:  eac_x_c = a_q;
      endcase
      eac_s_c = {1'b0, eac_x_c} + {1'b0, b_q};
      eac_c   = eac_s_c[WIDTH-1:0] + WIDTH'(eac_s_c[WIDTH]);

      step_c = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
      shf_c  = b_q[WIDTH-1] ? (sh_q >> step_c) : (sh_q << step_c);

      // a_q/b_q act as shift registers so every position is read at a fixed bit
      pk_acc_c = sh_q[WIDTH-1:0];
      pk_a_c   = a_q;
      pk_b_c   = b_q;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (op_q == OP_PACK) begin
            if (pk_b_c[0]) pk_acc_c = {pk_a_c[0], pk_acc_c[WIDTH-1:1]};
            pk_a_c = pk_a_c >> 1;
            pk_b_c = pk_b_c >> 1;
         end else begin
            if (pk_b_c[WIDTH-1]) begin
               pk_acc_c = {pk_acc_c[WIDTH-2:0], pk_a_c[WIDTH-1]};
               pk_a_c   = pk_a_c << 1;
            end else begin
               pk_acc_c = {pk_acc_c[WIDTH-2:0], 1'b0};
            end
            pk_b_c = pk_b_c << 1;
         end
      end
   end

`ifdef MESM6_ALU_MUL_EN
   logic [WIDTH:0]     mul_sum_c;
   logic [2*WIDTH-1:0] mul_c;

   // One shift-add multiply step: multiplier in the low half, partial product in the high half.
   always_comb begin
      mul_sum_c = {1'b0, sh_q[2*WIDTH-1:WIDTH]};
      if (sh_q[0]) mul_sum_c = mul_sum_c + {1'b0, a_q};
      mul_c = {mul_sum_c, sh_q[WIDTH-1:1]};
   end
`endif

   // Control FSM with registered result, Y, busy and done.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         y_q      <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  cnt_q   <= '0;
                  sh_q    <= '0;
                  // single-cycle ops complete at this edge; multicycle ops override below
                  state_q <= FIN;
                  done_q  <= 1'b1;
                  case (op)
                     OP_NOP: if (wy) y_q <= a;
                     OP_AND: begin result_q <= a & b; y_q <= '0; end
                     OP_OR:  begin result_q <= a | b; y_q <= '0; end
                     OP_XOR: begin result_q <= a ^ b; y_q <= a;  end
                     OP_YTA: result_q <= y_q;
                     OP_ADDC, OP_COUNT, OP_CLZ, OP_PACK, OP_UNPACK: begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                     end
                     OP_SHIFT: begin
                        sh_q    <= b[WIDTH-1] ? {a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a};
                        cnt_q   <= CW'(b[WIDTH-2 -: 6]);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                     end
`ifdef MESM6_ALU_MUL_EN
                     OP_MUL: begin
                        sh_q    <= {{WIDTH{1'b0}}, b};
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            RUN: begin
               case (op_q)
                  OP_ADDC, OP_COUNT, OP_CLZ: begin
                     result_q <= eac_c;
                     y_q      <= (op_q == OP_CLZ) ? (a_q << clz_c) : '0;
                     state_q  <= FIN;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
                  OP_SHIFT: begin
                     sh_q  <= shf_c;
                     cnt_q <= cnt_q - step_c;
                     if (cnt_q == step_c) begin
                        if (b_q[WIDTH-1]) {result_q, y_q} <= shf_c;
                        else              {y_q, result_q} <= shf_c;
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
                  OP_PACK, OP_UNPACK: begin
                     sh_q[WIDTH-1:0] <= pk_acc_c;
                     a_q             <= pk_a_c;
                     b_q             <= pk_b_c;
                     cnt_q           <= cnt_q + 1'b1;
                     if (cnt_q == CW'(NCHUNK - 1)) begin
                        result_q <= pk_acc_c;
                        y_q      <= '0;
                        state_q  <= FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                     end
                  end
`ifdef MESM6_ALU_MUL_EN
                  OP_MUL: begin
                     sh_q  <= mul_c;
                     cnt_q <= cnt_q + 1'b1;
                     if (cnt_q == CW'(WIDTH - 1)) begin
                        {result_q, y_q} <= mul_c;
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
`endif
                  default: begin
                     state_q <= FIN;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               endcase
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
